// File: rtl/gate_pkg.sv
// Shared types for the gate-unit arbiter: opcode encoding and arbiter FSM states.
package gate_pkg;

    localparam int OP_WIDTH = 2;

    typedef enum logic [1:0] {
        GATE_AND = 2'd0,
        GATE_OR  = 2'd1,
        GATE_XOR = 2'd2,
        GATE_NOT = 2'd3
    } gate_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or after i_ptr, wrapping.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    logic [IW:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!o_any && i_valid[w_cand[IW-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_cand[IW-1:0];
            end
        end
        o_grant[o_idx] = o_any;
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin sequencer sharing one bitwise gate unit among NUM_REQ requesters.
// States: IDLE arbitrate/grant | ISSUE start pulse | WAIT for unit done | RESP hold response.
module gate_unit_arbiter
    import gate_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int OP_WIDTH   = gate_pkg::OP_WIDTH,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic                          unit_start_o,
    output logic [OP_WIDTH-1:0]           unit_op_o,
    output logic [DATA_WIDTH-1:0]         unit_a_o,
    output logic [DATA_WIDTH-1:0]         unit_b_o,
    input  logic                          unit_done_i,
    input  logic [DATA_WIDTH-1:0]         unit_result_i,
    output logic                          rsp_valid_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    input  logic                          rsp_ready_i,
    output logic                          busy_o
);

    arb_state_e              r_state;
    logic [ID_WIDTH-1:0]     r_ptr;
    logic [ID_WIDTH-1:0]     r_id;
    logic [OP_WIDTH-1:0]     r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;

    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_WIDTH-1:0]     w_idx;
    logic                    w_any;
    logic [ID_WIDTH-1:0]     w_ptr_next;

    rr_picker #(.N(NUM_REQ)) u_picker (
        .i_valid (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_ptr_next = (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_idx;
                        r_op    <= req_op_i[w_idx*OP_WIDTH +: OP_WIDTH];
                        r_a     <= req_a_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_b     <= req_b_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_ptr   <= w_ptr_next;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (unit_done_i) begin
                        r_rsp_data  <= unit_result_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    // Grant for the next op waits for the following IDLE cycle.
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (r_state == IDLE) ? w_grant : '0;
    assign unit_start_o = (r_state == ISSUE);
    assign unit_op_o    = r_op;
    assign unit_a_o     = r_a;
    assign unit_b_o     = r_b;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_id;
    assign rsp_data_o   = r_rsp_data;
    assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter: vector table plus hand-written corner sequences.
module tb_gate_unit_arbiter;
    import gate_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        unit_start;
    logic [1:0]  unit_op;
    logic [7:0]  unit_a;
    logic [7:0]  unit_b;
    logic        unit_done;
    logic [7:0]  unit_result;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_ready;
    logic        busy;

    always #5 clk = ~clk;

    gate_unit_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .unit_start_o  (unit_start),
        .unit_op_o     (unit_op),
        .unit_a_o      (unit_a),
        .unit_b_o      (unit_b),
        .unit_done_i   (unit_done),
        .unit_result_i (unit_result),
        .rsp_valid_o   (rsp_valid),
        .rsp_id_o      (rsp_id),
        .rsp_data_o    (rsp_data),
        .rsp_ready_i   (rsp_ready),
        .busy_o        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Gate unit model: done one cycle after start, result from the latched operands.
    logic       auto_done = 1'b1;
    logic       pend = 1'b0;
    logic [7:0] pend_res = 8'h00;
    int         spur_cnt = 0;
    int         spur_seen = 0;

    function automatic logic [7:0] gate_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (gate_op_e'(op))
            GATE_AND: return a & b;
            GATE_OR:  return a | b;
            GATE_XOR: return a ^ b;
            default:  return ~a;
        endcase
    endfunction

    initial begin
        unit_done   = 1'b0;
        unit_result = 8'h00;
        forever begin
            @(negedge clk);
            unit_done = 1'b0;
            if (pend) begin
                unit_done   = 1'b1;
                unit_result = pend_res;
                pend        = 1'b0;
            end else if (spur_seen != spur_cnt) begin
                unit_done   = 1'b1;
                unit_result = 8'hAA;
                spur_seen   = spur_cnt;
            end
            if (unit_start && auto_done) begin
                pend     = 1'b1;
                pend_res = gate_fn(unit_op, unit_a, unit_b);
            end
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        int          id;
        logic [7:0]  data;
    } vec_t;

    // Standard operands: r0 XOR 5A,FF=A5; r1 AND F0,3C=30; r2 OR 81,18=99; r3 NOT 0F=F0
    localparam logic [7:0]  OPS = 8'hD2;
    localparam logic [31:0] AS  = 32'h0F81_F05A;
    localparam logic [31:0] BS  = 32'h7718_3CFF;

    vec_t tv[12];

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int n;
        req_valid = v.valid;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("v%0d_grant", k), {28'd0, req_ready}, {28'd0, v.gnt});
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        chk($sformatf("v%0d_start", k), {31'd0, unit_start}, 32'd1);
        chk($sformatf("v%0d_unit_a", k), {24'd0, unit_a}, {24'd0, v.a[v.id*8 +: 8]});
        chk($sformatf("v%0d_unit_b", k), {24'd0, unit_b}, {24'd0, v.b[v.id*8 +: 8]});
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("v%0d_latency", k), n, 3);
        chk($sformatf("v%0d_rsp_id", k), {30'd0, rsp_id}, v.id);
        chk($sformatf("v%0d_rsp_data", k), {24'd0, rsp_data}, {24'd0, v.data});
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[6];
        int gcyc[6];
        int ng;
        int cyc;
        int n;

        tv[0]  = '{4'b0010, OPS,   AS, BS, 4'b0010, 1, 8'h30};
        tv[1]  = '{4'b0011, OPS,   AS, BS, 4'b0001, 0, 8'hA5};
        tv[2]  = '{4'b1111, OPS,   AS, BS, 4'b0010, 1, 8'h30};
        tv[3]  = '{4'b1111, OPS,   AS, BS, 4'b0100, 2, 8'h99};
        tv[4]  = '{4'b1111, OPS,   AS, BS, 4'b1000, 3, 8'hF0};
        tv[5]  = '{4'b1111, OPS,   AS, BS, 4'b0001, 0, 8'hA5};
        tv[6]  = '{4'b1111, OPS,   AS, BS, 4'b0010, 1, 8'h30};
        tv[7]  = '{4'b0100, OPS,   AS, BS, 4'b0100, 2, 8'h99};
        tv[8]  = '{4'b1010, OPS,   AS, BS, 4'b1000, 3, 8'hF0};
        tv[9]  = '{4'b1010, OPS,   AS, BS, 4'b0010, 1, 8'h30};
        tv[10] = '{4'b1100, OPS,   AS, BS, 4'b0100, 2, 8'h99};
        tv[11] = '{4'b1000, 8'h92, 32'hC381_F05A, 32'h3C18_3CFF, 4'b1000, 3, 8'hFF};

        rst_n     = 1'b0;
        req_valid = 4'b0;
        req_op    = OPS;
        req_a     = AS;
        req_b     = BS;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_start", {31'd0, unit_start}, 32'd0);
        chk("rst_unit", {14'd0, unit_op, unit_a, unit_b}, 32'd0);
        chk("rst_rsp", {21'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 12; k++) run_vec(k, tv[k]);

        // Fairness: all valid continuously from pointer 0.
        req_op = OPS; req_a = AS; req_b = BS;
        req_valid = 4'b1111;
        ng = 0;
        cyc = 0;
        #1;
        while (ng < 6 && cyc < 60) begin
            if (req_ready != 4'b0) begin
                gid[ng] = 0;
                for (int j = 0; j < 4; j++) if (req_ready[j]) gid[ng] = j;
                gcyc[ng] = cyc;
                ng++;
            end
            if (ng < 6) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        chk("fair_count", ng, 6);
        for (int j = 0; j < 6; j++) begin
            if (j < ng) chk($sformatf("fair_id%0d", j), gid[j], j % 4);
            if (j > 0 && j < ng) chk($sformatf("fair_gap%0d", j), gcyc[j] - gcyc[j-1], 4);
        end
        @(negedge clk);
        req_valid = 4'b0;
        wait_idle();

        // Backpressure: pointer now 2, everyone valid, consumer stalls 5 cycles.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("bp_grant", {28'd0, req_ready}, 32'h4);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("bp_hold%0d", j), {17'd0, rsp_valid, req_ready, 2'd0, rsp_id, rsp_data},
                {17'd0, 1'b1, 4'b0000, 2'd0, 2'd2, 8'h99});
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("bp_next_grant", {28'd0, req_ready}, 32'h8);
        @(negedge clk);
        req_valid = 4'b0;
        n = 0;
        #1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_next_rsp", {22'd0, rsp_id, rsp_data}, {22'd0, 2'd3, 8'hF0});
        wait_idle();

        // Spurious done while idle.
        spur_cnt++;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("spur%0d", j), {30'd0, rsp_valid, busy}, 32'd0);
        end

        // Reset during WAIT: pointer 0, only req 2 valid.
        auto_done = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("rw_grant", {28'd0, req_ready}, 32'h4);
        @(negedge clk);
        req_valid = 4'b0;
        @(negedge clk);
        #1;
        chk("rw_in_wait", {30'd0, busy, unit_start}, 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rw_rst_outs", {8'd0, req_ready, unit_start, unit_op, unit_a, rsp_valid, rsp_id, busy},
            32'd0);
        chk("rw_rst_data", {16'd0, unit_b, rsp_data}, 32'd0);
        rst_n = 1'b1;
        auto_done = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rw_no_rsp%0d", j), {31'd0, rsp_valid}, 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("rw_ptr_zero", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
